dwt_haar_pass_ctrl: RTL and testbench

- Initiator-side controller for the dual-port 8-bit image memory.
- Runs one in-place integer Haar lifting pass over the whole HEIGHTxWIDTH image, either along rows or along columns.
- Uses both memory ports to read a sample pair, then computes the low/high coefficients and writes them back to the same two addresses.
- Sits between the top-level sequencer and the image memory; the sequencer issues a row pass, then a column pass, for each 2D DWT level.

---
 rtl/dwt_haar_pass_ctrl_if.sv | 44 ++++
 rtl/dwt_haar_pass_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dwt_haar_pass_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dwt_haar_pass_ctrl_if.sv
// ---------------------------------------------------------------------------
// dwt_haar_pass_ctrl_if
//   Bundles both ports of the dual-port 8-bit image memory so they can be
//   passed around as one object.
//
//   master : the pass controller. It drives the enables, write enables,
//            addresses and write data, and receives the read data.
//   slave  : the image memory. Its read data is registered, so an address
//            presented in cycle t returns data in cycle t+1.
//
//   Port 1 carries the even sample of a pair (L coefficient on write).
//   Port 2 carries the odd sample of a pair (H coefficient on write).
// ---------------------------------------------------------------------------
interface dwt_haar_pass_ctrl_if #(
    parameter int AW = 16
) ();

    logic          mem_en1;
    logic          mem_we1;
    logic [AW-1:0] mem_addr1;
    logic [7:0]    mem_wdata1;
    logic [7:0]    mem_rdata1;

    logic          mem_en2;
    logic          mem_we2;
    logic [AW-1:0] mem_addr2;
    logic [7:0]    mem_wdata2;
    logic [7:0]    mem_rdata2;

    modport master (
        output mem_en1, mem_we1, mem_addr1, mem_wdata1,
        input  mem_rdata1,
        output mem_en2, mem_we2, mem_addr2, mem_wdata2,
        input  mem_rdata2
    );

    modport slave (
        input  mem_en1, mem_we1, mem_addr1, mem_wdata1,
        output mem_rdata1,
        input  mem_en2, mem_we2, mem_addr2, mem_wdata2,
        output mem_rdata2
    );

endinterface

// File: rtl/dwt_haar_pass_ctrl.sv
// ---------------------------------------------------------------------------
// dwt_haar_pass_ctrl
//   Runs one in-place integer Haar lifting pass over a HEIGHT x WIDTH 8-bit
//   image held in a dual-port memory, along rows (mode=0) or columns
//   (mode=1). Each sample pair (a, b) is read on both ports at once, turned
//   into L = (a+b)>>1 and H = (a-b+256)>>1, and written back to the same two
//   addresses. A pair costs three cycles: RD, CALC, WR.
//
//   Ports
//     clk    : rising-edge clock
//     rst    : synchronous, active-high reset
//     start  : pulse; begins a pass when idle (ignored otherwise)
//     mode   : sampled with start; 0 = row pass, 1 = column pass
//     busy   : high while pairs are being processed
//     done   : one-cycle pulse when the pass completes
//     mem    : both memory ports (master side)
// ---------------------------------------------------------------------------
module dwt_haar_pass_ctrl #(
    parameter  int HEIGHT = 256,
    parameter  int WIDTH  = 256,
    localparam int AW     = $clog2(HEIGHT * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    output logic                 busy,
    output logic                 done,
    dwt_haar_pass_ctrl_if.master mem
);

    localparam int LOG2_W  = $clog2(WIDTH);
    localparam int MAX_DIM = (HEIGHT > WIDTH) ? HEIGHT : WIDTH;
    localparam int OW      = $clog2(MAX_DIM);      // outer counter width
    localparam int IW      = $clog2(MAX_DIM / 2);  // inner counter width

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CALC,
        WR,
        FIN
    } state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [OW-1:0] outer_q, outer_d;
    logic [IW-1:0] inner_q, inner_d;
    logic [7:0]    l_q, l_d;
    logic [7:0]    h_q, h_d;

    logic [OW-1:0] outer_max;
    logic [IW-1:0] inner_max;
    logic          last_pair;
    logic [AW-1:0] addr1, addr2;
    logic [8:0]    sum, diff;
    logic          en, we;

    // Row pass walks r (outer) x k (inner, pair index along the row);
    // column pass walks c (outer) x k (inner, pair index down the column).
    always_comb begin
        outer_max = mode_q ? OW'(WIDTH - 1)     : OW'(HEIGHT - 1);
        inner_max = mode_q ? IW'(HEIGHT / 2 - 1) : IW'(WIDTH / 2 - 1);
        last_pair = (outer_q == outer_max) && (inner_q == inner_max);
    end

    // Multiplies by WIDTH are shifts; the added terms never carry into the
    // shifted field, so OR and + are interchangeable here.
    always_comb begin
        if (!mode_q) begin
            addr1 = (AW'(outer_q) << LOG2_W) | (AW'(inner_q) << 1);
            addr2 = addr1 | AW'(1);
        end else begin
            addr1 = (AW'(inner_q) << (LOG2_W + 1)) | AW'(outer_q);
            addr2 = addr1 + AW'(WIDTH);
        end
    end

    // 9-bit lifting: {1,a} - {0,b} equals a - b + 256, always in 1..511.
    always_comb begin
        sum  = {1'b0, mem.mem_rdata1} + {1'b0, mem.mem_rdata2};
        diff = {1'b1, mem.mem_rdata1} - {1'b0, mem.mem_rdata2};
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        outer_d = outer_q;
        inner_d = inner_q;
        l_d     = l_q;
        h_d     = h_q;
        en      = 1'b0;
        we      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    outer_d = '0;
                    inner_d = '0;
                    state_d = RD;
                end
            end
            RD: begin
                busy    = 1'b1;
                en      = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                busy    = 1'b1;
                l_d     = 8'(sum >> 1);
                h_d     = 8'(diff >> 1);
                state_d = WR;
            end
            WR: begin
                busy = 1'b1;
                en   = 1'b1;
                we   = 1'b1;
                if (last_pair) begin
                    state_d = FIN;
                end else begin
                    state_d = RD;
                    if (inner_q == inner_max) begin
                        inner_d = '0;
                        outer_d = outer_q + 1'b1;
                    end else begin
                        inner_d = inner_q + 1'b1;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Enables are masked by rst so that a reset landing on a WR cycle stops
    // that write too, leaving only fully written pairs behind.
    always_comb begin
        mem.mem_en1    = en & ~rst;
        mem.mem_en2    = en & ~rst;
        mem.mem_we1    = we & ~rst;
        mem.mem_we2    = we & ~rst;
        mem.mem_addr1  = en ? addr1 : '0;
        mem.mem_addr2  = en ? addr2 : '0;
        mem.mem_wdata1 = we ? l_q : 8'd0;
        mem.mem_wdata2 = we ? h_q : 8'd0;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from the same edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            outer_q <= '0;
            inner_q <= '0;
            l_q     <= 8'd0;
            h_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            outer_q <= outer_d;
            inner_q <= inner_d;
            l_q     <= l_d;
            h_q     <= h_d;
        end
    end

endmodule

// File: tb/tb_dwt_haar_pass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dwt_haar_pass_ctrl
//   Two controllers share one clock: a 4x4 instance for the directed cases
//   and a 16-row x 32-column instance for randomized whole-image passes.
//   Each has its own behavioural dual-port memory with registered reads.
//   Expected images and address sequences come from a loop-level model of
//   the Haar pass.
// ---------------------------------------------------------------------------
module tb_dwt_haar_pass_ctrl;

    localparam int SH  = 4;
    localparam int SW  = 4;
    localparam int SAW = 4;
    localparam int LH  = 16;
    localparam int LW  = 32;
    localparam int LAW = 9;

    typedef struct {
        int a1;
        int a2;
        bit we;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, start_s, mode_s, busy_s, done_s;
    logic rst_l, start_l, mode_l, busy_l, done_l;

    dwt_haar_pass_ctrl_if #(.AW(SAW)) ifs ();
    dwt_haar_pass_ctrl_if #(.AW(LAW)) ifl ();

    dwt_haar_pass_ctrl #(.HEIGHT(SH), .WIDTH(SW)) dut_s (
        .clk   (clk),
        .rst   (rst_s),
        .start (start_s),
        .mode  (mode_s),
        .busy  (busy_s),
        .done  (done_s),
        .mem   (ifs.master)
    );

    dwt_haar_pass_ctrl #(.HEIGHT(LH), .WIDTH(LW)) dut_l (
        .clk   (clk),
        .rst   (rst_l),
        .start (start_l),
        .mode  (mode_l),
        .busy  (busy_l),
        .done  (done_l),
        .mem   (ifl.master)
    );

    logic [7:0] mem_s [SH*SW];
    logic [7:0] mem_l [LH*LW];
    ev_t        log_s [$];
    ev_t        log_l [$];
    ev_t        exp_log [$];
    int         ref_img [];
    int         coll_s = 0;
    int         coll_l = 0;
    int         checks = 0;
    int         errors = 0;

    // Memories: registered read returning pre-write data, then write.
    always @(posedge clk) begin
        if (ifs.mem_en1 || ifs.mem_en2)
            log_s.push_back('{int'(ifs.mem_addr1), int'(ifs.mem_addr2), ifs.mem_we1});
        if (ifs.mem_en1 && ifs.mem_en2 && ifs.mem_addr1 == ifs.mem_addr2) coll_s++;
        if (ifs.mem_en1) ifs.mem_rdata1 <= mem_s[ifs.mem_addr1];
        if (ifs.mem_en2) ifs.mem_rdata2 <= mem_s[ifs.mem_addr2];
        if (ifs.mem_en1 && ifs.mem_we1) mem_s[ifs.mem_addr1] = ifs.mem_wdata1;
        if (ifs.mem_en2 && ifs.mem_we2) mem_s[ifs.mem_addr2] = ifs.mem_wdata2;
    end

    always @(posedge clk) begin
        if (ifl.mem_en1 || ifl.mem_en2)
            log_l.push_back('{int'(ifl.mem_addr1), int'(ifl.mem_addr2), ifl.mem_we1});
        if (ifl.mem_en1 && ifl.mem_en2 && ifl.mem_addr1 == ifl.mem_addr2) coll_l++;
        if (ifl.mem_en1) ifl.mem_rdata1 <= mem_l[ifl.mem_addr1];
        if (ifl.mem_en2) ifl.mem_rdata2 <= mem_l[ifl.mem_addr2];
        if (ifl.mem_en1 && ifl.mem_we1) mem_l[ifl.mem_addr1] = ifl.mem_wdata1;
        if (ifl.mem_en2 && ifl.mem_we2) mem_l[ifl.mem_addr2] = ifl.mem_wdata2;
    end

    // ---------------- reference model and helpers ----------------

    // Haar pass over ref_img, stopping after npairs pairs; also records the
    // expected RD/WR address events.
    task automatic model_pass(input int h, input int w, input bit m, input int npairs);
        int n_outer, n_inner, cnt, i, j, a, b;
        exp_log.delete();
        n_outer = m ? w : h;
        n_inner = m ? h / 2 : w / 2;
        cnt = 0;
        for (int o = 0; o < n_outer; o++) begin
            for (int k = 0; k < n_inner; k++) begin
                if (cnt < npairs) begin
                    i = m ? (2 * k * w + o) : (o * w + 2 * k);
                    j = m ? (i + w) : (i + 1);
                    a = ref_img[i];
                    b = ref_img[j];
                    ref_img[i] = (a + b) / 2;
                    ref_img[j] = (a - b + 256) / 2;
                    exp_log.push_back('{i, j, 1'b0});
                    exp_log.push_back('{i, j, 1'b1});
                    cnt++;
                end
            end
        end
    endtask

    task automatic fill_random(input int sel);
        if (sel == 0) for (int i = 0; i < SH*SW; i++) mem_s[i] = 8'($urandom);
        else          for (int i = 0; i < LH*LW; i++) mem_l[i] = 8'($urandom);
    endtask

    task automatic load_ref(input int sel);
        int n;
        n = (sel == 0) ? SH*SW : LH*LW;
        ref_img = new[n];
        for (int i = 0; i < n; i++) ref_img[i] = (sel == 0) ? int'(mem_s[i]) : int'(mem_l[i]);
    endtask

    function automatic int mem_diffs(input int sel);
        int nd = 0;
        for (int i = 0; i < ref_img.size(); i++) begin
            if (sel == 0) begin
                if (int'(mem_s[i]) !== ref_img[i]) nd++;
            end else begin
                if (int'(mem_l[i]) !== ref_img[i]) nd++;
            end
        end
        return nd;
    endfunction

    function automatic int log_diffs(input int sel);
        int nd, n, la;
        ev_t e;
        la = (sel == 0) ? log_s.size() : log_l.size();
        n  = (la < exp_log.size()) ? la : exp_log.size();
        nd = (la > exp_log.size()) ? la - exp_log.size() : exp_log.size() - la;
        for (int i = 0; i < n; i++) begin
            e = (sel == 0) ? log_s[i] : log_l[i];
            if (e.a1 != exp_log[i].a1 || e.a2 != exp_log[i].a2 || e.we != exp_log[i].we) nd++;
        end
        return nd;
    endfunction

    task automatic clear_log(input int sel);
        if (sel == 0) log_s.delete(); else log_l.delete();
    endtask

    task automatic drive(input int sel, input logic st, input logic md);
        if (sel == 0) begin start_s = st; mode_s = md; end
        else          begin start_l = st; mode_l = md; end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_s : done_l;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_s : busy_l;
    endfunction

    // Starts a pass (start drawn in cycle 0) and watches busy/done for a
    // bounded window ending three cycles past the expected done.
    task automatic run_pass(input int sel, input bit m, input int exp_done, input bit disturb,
                            output int done_at, output int ndone, output int busy_err);
        int cyc;
        done_at = -1;
        ndone = 0;
        busy_err = 0;
        clear_log(sel);
        @(negedge clk);
        drive(sel, 1'b1, m);
        @(negedge clk);
        drive(sel, 1'b0, m);
        cyc = 1;
        while (cyc <= exp_done + 3) begin
            if (get_done(sel) === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = cyc;
            end
            if (get_busy(sel) !== (cyc < exp_done)) busy_err++;
            if (disturb) begin
                if (cyc == 5 || cyc == 12) drive(sel, 1'b1, ~m);
                else drive(sel, 1'b0, (cyc % 7 == 0) ? ~m : m);
            end
            @(negedge clk);
            cyc++;
        end
        drive(sel, 1'b0, m);
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rst_s = 1'b1; rst_l = 1'b1;
        start_s = 1'b1; mode_s = 1'b0;     // start held with rst: rst wins
        start_l = 1'b0; mode_l = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_s); end
        checks++; if ({ifs.mem_en1, ifs.mem_en2} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", {ifs.mem_en1, ifs.mem_en2}); end
        checks++; if ({ifs.mem_we1, ifs.mem_we2} !== 2'b00) begin errors++; $display("FAIL reset_we: got %b want 00", {ifs.mem_we1, ifs.mem_we2}); end
        checks++; if (ifs.mem_addr1 !== '0 || ifs.mem_addr2 !== '0) begin errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", ifs.mem_addr1, ifs.mem_addr2); end
        checks++; if (ifs.mem_wdata1 !== 8'd0 || ifs.mem_wdata2 !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %0d/%0d want 0/0", ifs.mem_wdata1, ifs.mem_wdata2); end
        checks++; if (busy_l !== 1'b0 || done_l !== 1'b0) begin errors++; $display("FAIL reset_large: busy %b done %b want 0 0", busy_l, done_l); end
        rst_s = 1'b0; rst_l = 1'b0; start_s = 1'b0;
        @(negedge clk);
        checks++; if (busy_s !== 1'b0 || ifs.mem_en1 !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy %b en %b want 0 0", busy_s, ifs.mem_en1); end
    endtask

    task automatic test_row_small();
        int done_at, ndone, berr;
        fill_random(0);
        mem_s[0] = 8'd200;
        mem_s[1] = 8'd100;
        load_ref(0);
        model_pass(SH, SW, 1'b0, SH*SW/2);
        run_pass(0, 1'b0, 25, 1'b0, done_at, ndone, berr);
        checks++; if (done_at !== 25) begin errors++; $display("FAIL row_done_cycle: got %0d want 25", done_at); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL row_done_count: got %0d want 1", ndone); end
        checks++; if (berr !== 0) begin errors++; $display("FAIL row_busy_window: %0d bad cycles want 0", berr); end
        checks++; if (mem_s[0] !== 8'd150 || mem_s[1] !== 8'd178) begin errors++; $display("FAIL row_pair0: got %0d/%0d want 150/178", mem_s[0], mem_s[1]); end
        checks++; if (mem_diffs(0) !== 0) begin errors++; $display("FAIL row_image: %0d bytes differ want 0", mem_diffs(0)); end
        checks++; if (log_diffs(0) !== 0) begin errors++; $display("FAIL row_addr_seq: %0d events differ want 0", log_diffs(0)); end
    endtask

    task automatic test_extremes();
        int done_at, ndone, berr;
        fill_random(0);
        mem_s[0] = 8'd0;   mem_s[1] = 8'd255;
        mem_s[2] = 8'd255; mem_s[3] = 8'd0;
        mem_s[4] = 8'd7;   mem_s[5] = 8'd7;
        run_pass(0, 1'b0, 25, 1'b0, done_at, ndone, berr);
        checks++; if (mem_s[0] !== 8'd127 || mem_s[1] !== 8'd0) begin errors++; $display("FAIL ext_0_255: got %0d/%0d want 127/0", mem_s[0], mem_s[1]); end
        checks++; if (mem_s[2] !== 8'd127 || mem_s[3] !== 8'd255) begin errors++; $display("FAIL ext_255_0: got %0d/%0d want 127/255", mem_s[2], mem_s[3]); end
        checks++; if (mem_s[4] !== 8'd7 || mem_s[5] !== 8'd128) begin errors++; $display("FAIL ext_7_7: got %0d/%0d want 7/128", mem_s[4], mem_s[5]); end
    endtask

    task automatic test_col_small();
        int done_at, ndone, berr, bad_off;
        fill_random(0);
        mem_s[2] = 8'd10;
        mem_s[6] = 8'd30;
        load_ref(0);
        model_pass(SH, SW, 1'b1, SH*SW/2);
        run_pass(0, 1'b1, 25, 1'b0, done_at, ndone, berr);
        bad_off = 0;
        foreach (log_s[i]) if (log_s[i].a2 != log_s[i].a1 + SW) bad_off++;
        checks++; if (done_at !== 25 || ndone !== 1) begin errors++; $display("FAIL col_done: at %0d count %0d want 25 1", done_at, ndone); end
        checks++; if (mem_s[2] !== 8'd20 || mem_s[6] !== 8'd118) begin errors++; $display("FAIL col_pair: got %0d/%0d want 20/118", mem_s[2], mem_s[6]); end
        checks++; if (bad_off !== 0 || log_s.size() !== 16) begin errors++; $display("FAIL col_port2_offset: %0d bad of %0d events want 0 of 16", bad_off, log_s.size()); end
        checks++; if (log_s.size() < 5 || log_s[0].a1 != 0 || log_s[0].a2 != 4 || log_s[2].a1 != 8 || log_s[2].a2 != 12 || log_s[4].a1 != 1 || log_s[4].a2 != 5) begin
            errors++; $display("FAIL col_first_addrs: sequence does not start 0/4 8/12 1/5 (got %0d events)", log_s.size());
        end
        checks++; if (mem_diffs(0) !== 0) begin errors++; $display("FAIL col_image: %0d bytes differ want 0", mem_diffs(0)); end
        checks++; if (log_diffs(0) !== 0) begin errors++; $display("FAIL col_addr_seq: %0d events differ want 0", log_diffs(0)); end
    endtask

    task automatic test_ignore_start();
        int done_at, ndone, berr;
        fill_random(0);
        load_ref(0);
        model_pass(SH, SW, 1'b1, SH*SW/2);
        run_pass(0, 1'b1, 25, 1'b1, done_at, ndone, berr);
        checks++; if (ndone !== 1 || done_at !== 25) begin errors++; $display("FAIL ignore_done: count %0d at %0d want 1 at 25", ndone, done_at); end
        checks++; if (berr !== 0) begin errors++; $display("FAIL ignore_busy: %0d bad cycles want 0", berr); end
        checks++; if (log_diffs(0) !== 0) begin errors++; $display("FAIL ignore_addr_seq: %0d events differ want 0", log_diffs(0)); end
        checks++; if (mem_diffs(0) !== 0) begin errors++; $display("FAIL ignore_image: %0d bytes differ want 0", mem_diffs(0)); end
    endtask

    task automatic test_rst_mid();
        int nwr, guard, ndone, nen, done_at, berr;
        fill_random(0);
        load_ref(0);
        model_pass(SH, SW, 1'b0, 4);
        @(negedge clk);
        drive(0, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0);
        nwr = 0;
        guard = 0;
        while (nwr < 5 && guard < 100) begin
            if (ifs.mem_we1 === 1'b1) nwr++;
            if (nwr < 5) begin
                @(negedge clk);
                guard++;
            end
        end
        checks++; if (nwr !== 5) begin errors++; $display("FAIL rst_find_wr5: saw %0d WR cycles want 5", nwr); end
        rst_s = 1'b1;
        #1;
        checks++; if (ifs.mem_we1 !== 1'b0 || ifs.mem_we2 !== 1'b0) begin errors++; $display("FAIL rst_blocks_write: we %b%b want 00", ifs.mem_we1, ifs.mem_we2); end
        @(negedge clk);
        rst_s = 1'b0;
        checks++; if (ifs.mem_en1 !== 1'b0 || busy_s !== 1'b0) begin errors++; $display("FAIL rst_next_edge: en %b busy %b want 0 0", ifs.mem_en1, busy_s); end
        ndone = 0;
        nen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_s !== 1'b0) ndone++;
            if (ifs.mem_en1 !== 1'b0 || ifs.mem_en2 !== 1'b0 || busy_s !== 1'b0) nen++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_no_done: %0d done cycles want 0", ndone); end
        checks++; if (nen !== 0) begin errors++; $display("FAIL rst_stays_idle: %0d active cycles want 0", nen); end
        checks++; if (mem_diffs(0) !== 0) begin errors++; $display("FAIL rst_partial_image: %0d bytes differ want 0", mem_diffs(0)); end
        load_ref(0);
        model_pass(SH, SW, 1'b0, SH*SW/2);
        run_pass(0, 1'b0, 25, 1'b0, done_at, ndone, berr);
        checks++; if (done_at !== 25 || ndone !== 1 || berr !== 0) begin errors++; $display("FAIL rst_restart: done at %0d count %0d busy errs %0d want 25 1 0", done_at, ndone, berr); end
        checks++; if (mem_diffs(0) !== 0) begin errors++; $display("FAIL rst_restart_image: %0d bytes differ want 0", mem_diffs(0)); end
    endtask

    task automatic test_large_random(input bit m);
        int done_at, ndone, berr, exp_done;
        exp_done = 3 * LH * LW / 2 + 1;
        fill_random(1);
        load_ref(1);
        model_pass(LH, LW, m, LH*LW/2);
        run_pass(1, m, exp_done, 1'b0, done_at, ndone, berr);
        checks++; if (done_at !== exp_done || ndone !== 1) begin errors++; $display("FAIL large_done mode %0d: at %0d count %0d want %0d 1", m, done_at, ndone, exp_done); end
        checks++; if (berr !== 0) begin errors++; $display("FAIL large_busy mode %0d: %0d bad cycles want 0", m, berr); end
        checks++; if (mem_diffs(1) !== 0) begin errors++; $display("FAIL large_image mode %0d: %0d bytes differ want 0", m, mem_diffs(1)); end
        checks++; if (log_diffs(1) !== 0) begin errors++; $display("FAIL large_addr_seq mode %0d: %0d events differ want 0", m, log_diffs(1)); end
    endtask

    initial begin
        test_reset();
        test_row_small();
        test_extremes();
        test_col_small();
        test_ignore_start();
        test_rst_mid();
        test_large_random(1'b0);
        test_large_random(1'b1);
        checks++; if (coll_s + coll_l !== 0) begin errors++; $display("FAIL port_collision: %0d same-address cycles want 0", coll_s + coll_l); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
